hack_fetch_unit: RTL and testbench
==================================

# hack_fetch_unit

Instruction fetch and program-counter stage of the Hack CPU. Fetches the 16-bit instruction at `pc` from instruction ROM over a request/valid handshake and holds it in an instruction register that drives the instruction decoder. It waits for the execute side to acknowledge completion, then resolves the jump condition from the held instruction and the ALU flags. The next PC is either `pc+1` or the A-register value.

## Interface
Parameters:
- `ADDR_W`, 15: ROM address width; PC width.
- `DATA_W`, 16: instruction width. Only the Hack encoding at 16 is supported.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `run`, input, 1: level enable. When low, the unit parks in IDLE after the current instruction retires.
- `rom_req`, output, 1: fetch request. Held high until `rom_valid` is seen.
- `rom_addr`, output, ADDR_W: fetch address. Equals `pc` whenever `rom_req` is high.
- `rom_valid`, input, 1: `rom_data` is valid this cycle. Ignored unless `rom_req` is high.
- `rom_data`, input, DATA_W: instruction word.
- `instr`, output, DATA_W: instruction register; feeds the decoder.
- `instr_valid`, output, 1: `instr` holds an unretired instruction.
- `exec_ack`, input, 1: execute side retires `instr` this cycle. Ignored unless `instr_valid` is high.
- `zr`, input, 1: ALU output == 0. Sampled in the `exec_ack` cycle.
- `ng`, input, 1: ALU output < 0. Sampled in the `exec_ack` cycle.
- `a_val`, input, ADDR_W: A register contents before this instruction's write; the jump target.
- `pc`, output, ADDR_W: address of the instruction being fetched or held.

## Operation
- States: IDLE, FETCH, ISSUE. Reset enters IDLE.
- IDLE: `rom_req`=0 and `instr_valid`=0. On `run`=1, go to FETCH next cycle.
- FETCH: `rom_req`=1 and `rom_addr`=`pc`. On `rom_valid`=1, load `instr`←`rom_data` and go to ISSUE.
- ISSUE: `instr_valid`=1. On `exec_ack`=1:
  - Update `pc`.
  - Go to FETCH if `run`=1, otherwise go to IDLE.
- Jump resolution, evaluated only in the `exec_ack` cycle:
  - A-instruction (`instr[15]`=0): never jumps.
  - C-instruction: j1=`instr[2]`, j2=`instr[1]`, j3=`instr[0]`.
  - taken = (j1 & ng) | (j2 & zr) | (j3 & !zr & !ng).
  - 111 is always taken; 000 is never taken.
- Next PC: `a_val` if taken, else `pc+1` modulo 2^ADDR_W. 0x7FFF+1 wraps to 0x0000.
- `run` dropping during FETCH or ISSUE does not abort. The outstanding fetch and the held instruction complete; the PC is updated; the unit then parks in IDLE.
- `rom_data` is captured only in FETCH with `rom_valid`=1. A stray `rom_valid` in IDLE or ISSUE changes nothing.

## Timing
- Reset values: `pc`=0, `instr`=0, `instr_valid`=0, `rom_req`=0, `rom_addr`=0, state IDLE.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronously), and any in-flight instruction is dropped.
- After `reset_n` rises with `run`=1: one cycle in IDLE, then `rom_req` asserts on the next edge.
- `rom_valid` may arrive in the first FETCH cycle (zero-wait ROM). `instr_valid` rises on the following edge.
- `exec_ack` may arrive in the first ISSUE cycle. `pc` updates and `rom_req` re-asserts on the following edge.
- Throughput with zero-wait ROM and immediate ack: one instruction per 2 cycles.
- `rom_req` and `instr_valid` are never high in the same cycle.
- All outputs are registered.

## Structure
- Shared package `hack_pkg`:
  - Field positions: `I_CINSTR`=15, `J1`=2, `J2`=1, `J3`=0.
  - State enum {IDLE, FETCH, ISSUE}.
  - `HACK_ADDR_W`=15.
- One combinational sub-module, `hack_jump_eval` (`instr`, `zr`, `ng` → `taken`). The jump/PC stage reuses it.

## Test plan
- Reset, then `run`=1, zero-wait ROM with ROM[0]=0x0005 and ROM[1]=0xE308, immediate `exec_ack` → `rom_addr` sequence 0, 1, 2, with `instr_valid` pulses exactly 2 cycles apart.
- ROM[2]=0xE302 (D;JEQ):
  - `zr`=1, `a_val`=0x0010 → next `rom_addr`=0x0010.
  - Repeated with `zr`=0 → next `rom_addr`=0x0003.
- JMP (0xEA87) at 0x7FFF with `a_val`=0x0123 → `pc`=0x0123. Non-jump instruction at 0x7FFF → `pc`=0x0000 (wrap).
- A-instruction 0x0007 with `zr`=1 and `ng`=1 → not taken, `pc`+1.
- Stall cases:
  - `rom_valid` delayed 3 cycles → `rom_req` and `rom_addr` held stable.
  - `exec_ack` delayed 4 cycles → `instr` and `instr_valid` held.
  - `rom_valid` pulsed during ISSUE → `instr` unchanged.
- `run`→0 during FETCH → fetch completes, ack accepted, `pc` advances, unit parks in IDLE with `rom_req`=0.
- `reset_n` pulsed low mid-ISSUE → `instr_valid`=0 and `pc`=0 asynchronously; fetch restarts at address 0.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU front end.
// Holds the Hack instruction field positions, the fetch FSM state
// encoding and the default address/data widths. Files that use it
// pull it in with import hack_pkg::*.
package hack_pkg;

  localparam int HACK_ADDR_W = 15;
  localparam int HACK_DATA_W = 16;

  // Hack instruction fields
  localparam int I_CINSTR = 15;  // 1 = C-instruction, 0 = A-instruction
  localparam int J1       = 2;   // jump if out < 0
  localparam int J2       = 1;   // jump if out == 0
  localparam int J3       = 0;   // jump if out > 0

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/hack_fetch_unit_if.sv
// Instruction ROM request/valid bus.
//   rom_req   : fetch request, held until rom_valid is seen
//   rom_addr  : fetch address
//   rom_valid : rom_data is valid this cycle
//   rom_data  : instruction word
// master = fetch unit side, slave = ROM side.
interface hack_fetch_unit_if #(
  parameter int ADDR_W = hack_pkg::HACK_ADDR_W,
  parameter int DATA_W = hack_pkg::HACK_DATA_W
) ();

  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_valid;
  logic [DATA_W-1:0] rom_data;

  modport master (
    output rom_req,
    output rom_addr,
    input  rom_valid,
    input  rom_data
  );

  modport slave (
    input  rom_req,
    input  rom_addr,
    output rom_valid,
    output rom_data
  );

endinterface

// File: rtl/hack_jump_eval.sv
// Combinational jump resolution for a Hack instruction.
//   instr : instruction being retired
//   zr    : ALU output == 0
//   ng    : ALU output < 0
//   taken : 1 when the next PC comes from the A register
// A-instructions never jump; for C-instructions the j1/j2/j3 bits
// select the lt/eq/gt conditions, so 111 is unconditional and 000 never.
module hack_jump_eval
  import hack_pkg::*;
(
  input  logic [HACK_DATA_W-1:0] instr,
  input  logic                   zr,
  input  logic                   ng,
  output logic                   taken
);

  logic cond;

  assign cond  = (instr[J1] & ng)
               | (instr[J2] & zr)
               | (instr[J3] & ~zr & ~ng);
  assign taken = instr[I_CINSTR] & cond;

  // Only the type bit and the jump field matter here.
  logic unused_fields;
  assign unused_fields = ^instr[I_CINSTR-1:J1+1];

endmodule

// File: rtl/hack_fetch_unit.sv
// Hack CPU instruction fetch / program counter stage.
//   clk, reset_n : clock, asynchronous active-low reset
//   run          : level enable; when low the unit parks in IDLE once
//                  the current instruction has retired
//   rom          : ROM request/valid bus (master side)
//   instr        : instruction register feeding the decoder
//   instr_valid  : instr holds an unretired instruction
//   exec_ack     : execute side retires instr this cycle
//   zr, ng       : ALU flags, sampled in the exec_ack cycle
//   a_val        : A register contents, the jump target
//   pc           : address of the instruction being fetched or held
// Flow: IDLE -> FETCH (request until rom_valid) -> ISSUE (hold until
// exec_ack, then update pc) -> FETCH or IDLE. All outputs are flops.
// Only the 16-bit Hack encoding is supported for DATA_W.
module hack_fetch_unit
  import hack_pkg::*;
#(
  parameter int ADDR_W = HACK_ADDR_W,
  parameter int DATA_W = HACK_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  hack_fetch_unit_if.master     rom,
  output logic [DATA_W-1:0]     instr,
  output logic                  instr_valid,
  input  logic                  exec_ack,
  input  logic                  zr,
  input  logic                  ng,
  input  logic [ADDR_W-1:0]     a_val,
  output logic [ADDR_W-1:0]     pc
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_ISSUE = ISSUE;

  logic [1:0]        state_q, state_d;
  logic              rom_req_q;
  logic              instr_valid_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              taken;
  logic              fetch_done;
  logic              retire;

  assign fetch_done = (state_q == ST_FETCH) & rom.rom_valid;
  assign retire     = (state_q == ST_ISSUE) & exec_ack;

  hack_jump_eval u_jump_eval (
    .instr (instr_q),
    .zr    (zr),
    .ng    (ng),
    .taken (taken)
  );

  // Natural overflow gives the 0x7FFF -> 0x0000 wrap.
  assign pc_d = taken ? a_val : pc_q + ADDR_W'(1);

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (run)           state_d = ST_FETCH;
      ST_FETCH: if (rom.rom_valid) state_d = ST_ISSUE;
      ST_ISSUE: if (exec_ack)      state_d = run ? ST_FETCH : ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      rom_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      pc_q          <= '0;
    end else begin
      state_q       <= state_d;
      // Strobes are registered from the next state so they line up
      // with the state they describe and never glitch.
      rom_req_q     <= (state_d == ST_FETCH);
      instr_valid_q <= (state_d == ST_ISSUE);
      if (fetch_done) instr_q <= rom.rom_data;
      if (retire)     pc_q    <= pc_d;
    end
  end

  assign rom.rom_req  = rom_req_q;
  // pc only changes on retire, so it is already stable while requesting.
  assign rom.rom_addr = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign pc           = pc_q;

endmodule

// File: tb/tb_hack_fetch_unit.sv
// Directed self-checking bench for hack_fetch_unit. The bench plays the
// ROM and the execute stage by hand, one clock at a time.
module tb_hack_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [15:0] instr;
  logic        instr_valid;
  logic        exec_ack;
  logic        zr;
  logic        ng;
  logic [14:0] a_val;
  logic [14:0] pc;

  int compared   = 0;
  int mismatched = 0;

  hack_fetch_unit_if #(.ADDR_W(15), .DATA_W(16)) rom_if ();

  hack_fetch_unit #(.ADDR_W(15), .DATA_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .rom         (rom_if.master),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_ack    (exec_ack),
    .zr          (zr),
    .ng          (ng),
    .a_val       (a_val),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Complete one fetch (zero-wait) and one immediate retire.
  // Entered in FETCH just after an edge; leaves in the state after retire.
  task automatic run_instr(input logic [15:0] word, input logic f_zr,
                           input logic f_ng, input logic [14:0] target);
    rom_if.rom_valid = 1'b1;
    rom_if.rom_data  = word;
    tick();
    rom_if.rom_valid = 1'b0;
    exec_ack = 1'b1;
    zr       = f_zr;
    ng       = f_ng;
    a_val    = target;
    tick();
    exec_ack = 1'b0;
    zr       = 1'b0;
    ng       = 1'b0;
  endtask

  initial begin
    reset_n          = 1'b0;
    run              = 1'b0;
    rom_if.rom_valid = 1'b0;
    rom_if.rom_data  = '0;
    exec_ack         = 1'b0;
    zr               = 1'b0;
    ng               = 1'b0;
    a_val            = '0;

    // Reset values
    #12;
    check("rst_pc",          32'(pc),              32'h0);
    check("rst_instr",       32'(instr),           32'h0);
    check("rst_instr_valid", 32'(instr_valid),     32'h0);
    check("rst_rom_req",     32'(rom_if.rom_req),  32'h0);
    check("rst_rom_addr",    32'(rom_if.rom_addr), 32'h0);

    // Release with run=1: leave IDLE on the first edge
    @(negedge clk);
    reset_n = 1'b1;
    run     = 1'b1;
    tick();
    check("start_rom_req",  32'(rom_if.rom_req),  32'h1);
    check("start_rom_addr", 32'(rom_if.rom_addr), 32'h0);

    // ROM[0] = 0x0005, zero-wait
    rom_if.rom_valid = 1'b1;
    rom_if.rom_data  = 16'h0005;
    tick();
    check("i0_valid",   32'(instr_valid),    32'h1);
    check("i0_instr",   32'(instr),          32'h0005);
    check("i0_rom_req", 32'(rom_if.rom_req), 32'h0);
    rom_if.rom_valid = 1'b0;
    exec_ack = 1'b1;
    tick();
    exec_ack = 1'b0;
    check("a1_rom_addr", 32'(rom_if.rom_addr), 32'h1);
    check("a1_rom_req",  32'(rom_if.rom_req),  32'h1);
    check("a1_ivalid",   32'(instr_valid),     32'h0);

    // ROM[1] = 0xE308 (no jump bits); instr_valid again 2 cycles later
    rom_if.rom_valid = 1'b1;
    rom_if.rom_data  = 16'hE308;
    tick();
    check("i1_valid", 32'(instr_valid), 32'h1);
    check("i1_instr", 32'(instr),       32'hE308);
    rom_if.rom_valid = 1'b0;
    exec_ack = 1'b1;
    a_val    = 15'h0444;
    tick();
    exec_ack = 1'b0;
    check("a2_rom_addr", 32'(rom_if.rom_addr), 32'h2);

    // D;JEQ at 2 with zr=0 -> falls through to 3
    run_instr(16'hE302, 1'b0, 1'b0, 15'h0010);
    check("jeq_nt_addr", 32'(rom_if.rom_addr), 32'h3);
    // D;JEQ at 3 with zr=1 -> jumps to 0x0010
    run_instr(16'hE302, 1'b1, 1'b0, 15'h0010);
    check("jeq_t_addr", 32'(rom_if.rom_addr), 32'h0010);

    // JMP to 0x7FFF, then JMP from 0x7FFF to 0x0123
    run_instr(16'hEA87, 1'b0, 1'b0, 15'h7FFF);
    check("jmp_to_top", 32'(pc), 32'h7FFF);
    run_instr(16'hEA87, 1'b0, 1'b0, 15'h0123);
    check("jmp_from_top", 32'(pc), 32'h0123);
    // Back to 0x7FFF, then a non-jump wraps to 0
    run_instr(16'hEA87, 1'b0, 1'b0, 15'h7FFF);
    run_instr(16'hE308, 1'b0, 1'b0, 15'h0555);
    check("wrap_pc", 32'(pc), 32'h0);

    // A-instruction with both flags set never jumps
    run_instr(16'h0007, 1'b1, 1'b1, 15'h0555);
    check("ainstr_pc", 32'(pc), 32'h1);

    // ROM stall: 3 cycles with no rom_valid
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_rom_req",  32'(rom_if.rom_req),  32'h1);
      check("stall_rom_addr", 32'(rom_if.rom_addr), 32'h1);
    end
    rom_if.rom_valid = 1'b1;
    rom_if.rom_data  = 16'hE308;
    tick();
    // Ack stall for 4 cycles with a stray rom_valid of different data
    rom_if.rom_data = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_instr",   32'(instr),          32'hE308);
      check("hold_ivalid",  32'(instr_valid),    32'h1);
      check("hold_rom_req", 32'(rom_if.rom_req), 32'h0);
    end
    rom_if.rom_valid = 1'b0;
    exec_ack = 1'b1;
    tick();
    exec_ack = 1'b0;
    check("after_stall_addr", 32'(rom_if.rom_addr), 32'h2);

    // run drops during FETCH: fetch and retire still complete
    run = 1'b0;
    tick();
    check("park_fetch_req", 32'(rom_if.rom_req), 32'h1);
    rom_if.rom_valid = 1'b1;
    rom_if.rom_data  = 16'h0007;
    tick();
    rom_if.rom_valid = 1'b0;
    check("park_ivalid", 32'(instr_valid), 32'h1);
    exec_ack = 1'b1;
    tick();
    exec_ack = 1'b0;
    check("park_pc",      32'(pc),             32'h3);
    check("park_rom_req", 32'(rom_if.rom_req), 32'h0);
    check("park_ivalid0", 32'(instr_valid),    32'h0);
    tick();
    check("idle_rom_req", 32'(rom_if.rom_req), 32'h0);

    // Reset in the middle of ISSUE
    run = 1'b1;
    tick();
    check("resume_addr", 32'(rom_if.rom_addr), 32'h3);
    rom_if.rom_valid = 1'b1;
    rom_if.rom_data  = 16'hE308;
    tick();
    rom_if.rom_valid = 1'b0;
    check("pre_rst_ivalid", 32'(instr_valid), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_ivalid", 32'(instr_valid),    32'h0);
    check("async_pc",     32'(pc),             32'h0);
    check("async_instr",  32'(instr),          32'h0);
    check("async_req",    32'(rom_if.rom_req), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("restart_req",  32'(rom_if.rom_req),  32'h1);
    check("restart_addr", 32'(rom_if.rom_addr), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
